// File: rtl/pri_dec_if.sv
// Decoder handshake and output bundle shared by pri_dec and its driver.
// master drives the code stream; slave is the decoder.
interface pri_dec_if;
  logic       en;
  logic       in_valid;
  logic [2:0] in_code;
  logic       in_par;
  logic       in_ready;
  logic [7:0] Y;
  logic       busy;
  logic       done;
  logic       err;

  modport master (
    output en, in_valid, in_code, in_par,
    input  in_ready, Y, busy, done, err
  );

  modport slave (
    input  en, in_valid, in_code, in_par,
    output in_ready, Y, busy, done, err
  );
endinterface

// File: rtl/pri_dec.sv
// 3-to-8 one-hot decoder that holds each decoded code for PULSE_LEN cycles.
// Optional odd-parity checking on accepted codes is enabled by macro PRI_DEC_PARITY_EN.
module pri_dec #(
  parameter int unsigned PULSE_LEN = 4
) (
  input logic  clk,
  input logic  rst_n,
  pri_dec_if.slave io_bus
);

  localparam int unsigned CntW = $clog2(PULSE_LEN + 1);
  localparam logic [CntW-1:0] CntLoad = CntW'(PULSE_LEN);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  typedef enum logic {StIdle, StHold} state_e;

  state_e          r_state, w_state_d;
  logic [CntW-1:0] r_cnt, w_cnt_d;
  logic [7:0]      r_y, w_y_d;
  logic            w_last;
  logic            w_ready;
  logic            w_accept;
  logic            w_par_ok;
  logic [7:0]      w_onehot;

  assign w_last   = (r_state == StHold) && (r_cnt == CntOne);
  // Gated by rst_n so the handshake stays closed for the whole reset interval.
  assign w_ready  = rst_n && io_bus.en && ((r_state == StIdle) || w_last);
  assign w_accept = io_bus.in_valid && w_ready;
  assign w_onehot = 8'b1 << io_bus.in_code;

`ifdef PRI_DEC_PARITY_EN
  logic r_err;

  assign w_par_ok = ^{io_bus.in_code, io_bus.in_par};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_accept && !w_par_ok;
    end
  end
`else
  logic w_unused_par;

  assign w_par_ok     = 1'b1;
  assign w_unused_par = io_bus.in_par;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_y     <= 8'h00;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_y     <= w_y_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_y_d     = r_y;
    if (!io_bus.en) begin
      w_state_d = StIdle;
      w_cnt_d   = '0;
      w_y_d     = 8'h00;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_accept && w_par_ok) begin
            w_state_d = StHold;
            w_cnt_d   = CntLoad;
            w_y_d     = w_onehot;
          end
        end
        StHold: begin
          if (r_cnt == CntOne) begin
            // A good code on the last cycle reloads with no zero gap.
            if (w_accept && w_par_ok) begin
              w_cnt_d = CntLoad;
              w_y_d   = w_onehot;
            end else begin
              w_state_d = StIdle;
              w_cnt_d   = '0;
              w_y_d     = 8'h00;
            end
          end else begin
            w_cnt_d = r_cnt - CntOne;
          end
        end
        default: begin
          w_state_d = StIdle;
          w_cnt_d   = '0;
          w_y_d     = 8'h00;
        end
      endcase
    end
  end

  always_comb begin
    io_bus.in_ready = w_ready;
    io_bus.Y        = r_y;
    io_bus.busy     = (r_state == StHold);
    io_bus.done     = io_bus.en && w_last;
`ifdef PRI_DEC_PARITY_EN
    io_bus.err      = r_err;
`else
    io_bus.err      = 1'b0;
`endif
  end

endmodule

// File: tb/tb_pri_dec.sv
// Scoreboard bench for pri_dec: PULSE_LEN=4 and PULSE_LEN=1 instances share one stimulus stream.
// Expected outputs come from an interval model of each hold window.
module tb_pri_dec;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pri_dec_if bus4();
  pri_dec_if bus1();

  pri_dec #(.PULSE_LEN(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .io_bus(bus4));
  pri_dec #(.PULSE_LEN(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .io_bus(bus1));

  typedef struct {
    logic [7:0] y;
    logic       busy;
    logic       done;
    logic       ready;
    logic       err;
  } exp_t;

  exp_t q4[$];
  exp_t q1[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Model state per instance: the current hold window [p_start, p_end] and its code.
  int pl[2]      = '{4, 1};
  int p_start[2] = '{0, 0};
  int p_end[2]   = '{-1, -1};
  int p_code[2]  = '{0, 0};
  int err_at[2]  = '{-1, -1};
  int cyc        = 0;

  task automatic check1(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at model cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic par_good(input logic [2:0] code);
    return ~^code;
  endfunction

  function automatic exp_t model_step(input int d, input logic en, input logic valid,
                                      input logic [2:0] code, input logic par);
    exp_t e;
    int   t = cyc;
    logic active = (t >= p_start[d]) && (t <= p_end[d]);
    logic par_ok;
`ifdef PRI_DEC_PARITY_EN
    par_ok = ($countones({code, par}) % 2) == 1;
`else
    par_ok = 1'b1;
`endif
    e.y     = active ? 8'(1 << p_code[d]) : 8'h00;
    e.busy  = active;
    e.ready = en && (!active || (t == p_end[d]));
    e.done  = en && active && (t == p_end[d]);
    e.err   = (err_at[d] == t);
    if (!en && active) p_end[d] = t;
    if (valid && e.ready) begin
      if (par_ok) begin
        p_start[d] = t + 1;
        p_end[d]   = t + pl[d];
        p_code[d]  = int'(code);
      end else begin
        err_at[d] = t + 1;
      end
    end
    return e;
  endfunction

  task automatic cycle(input logic en, input logic valid, input logic [2:0] code,
                       input logic par);
    exp_t e;
    bus4.en = en; bus4.in_valid = valid; bus4.in_code = code; bus4.in_par = par;
    bus1.en = en; bus1.in_valid = valid; bus1.in_code = code; bus1.in_par = par;
    e = model_step(0, en, valid, code, par);
    q4.push_back(e);
    e = model_step(1, en, valid, code, par);
    q1.push_back(e);
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [2:0] code);
    cycle(1'b1, 1'b1, code, par_good(code));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 3'd0, 1'b0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    check1("rst Y L4", bus4.Y, 8'h00);
    check1("rst busy L4", 8'(bus4.busy), 8'd0);
    check1("rst in_ready L4", 8'(bus4.in_ready), 8'd0);
    check1("rst done L4", 8'(bus4.done), 8'd0);
    check1("rst err L4", 8'(bus4.err), 8'd0);
    check1("rst Y L1", bus1.Y, 8'h00);
    check1("rst in_ready L1", 8'(bus1.in_ready), 8'd0);
    for (int d = 0; d < 2; d++) begin
      p_end[d]  = -1;
      err_at[d] = -1;
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic compare(input string tag, input logic [7:0] y, input logic busy,
                         input logic done, input logic ready, input logic err, input exp_t e);
    check1({tag, " Y"}, y, e.y);
    check1({tag, " busy"}, 8'(busy), 8'(e.busy));
    check1({tag, " done"}, 8'(done), 8'(e.done));
    check1({tag, " in_ready"}, 8'(ready), 8'(e.ready));
    check1({tag, " err"}, 8'(err), 8'(e.err));
    check1({tag, " Y onehot"}, 8'($countones(y) <= 1), 8'd1);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q4.size() > 0) begin
      e = q4.pop_front();
      compare("L4", bus4.Y, bus4.busy, bus4.done, bus4.in_ready, bus4.err, e);
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      compare("L1", bus1.Y, bus1.busy, bus1.done, bus1.in_ready, bus1.err, e);
    end
  end

  initial begin
    bus4.en = 1'b1; bus4.in_valid = 1'b0; bus4.in_code = 3'd0; bus4.in_par = 1'b0;
    bus1.en = 1'b1; bus1.in_valid = 1'b0; bus1.in_code = 3'd0; bus1.in_par = 1'b0;
    @(posedge clk);
    #1;
    apply_reset();
    idle(1);

    // Single code held for the full window.
    offer(3'd5);
    idle(6);

    // Back-to-back: code 7 waits for the last cycle of code 2.
    offer(3'd2);
    for (int i = 0; i < 4; i++) offer(3'd7);
    idle(6);

    // Abort by dropping en mid-hold.
    offer(3'd3);
    idle(1);
    cycle(1'b0, 1'b0, 3'd0, 1'b0);
    idle(4);

    // One code per cycle.
    for (int i = 0; i < 8; i++) offer(3'(i));
    idle(5);

    // Parity: good then bad encoding of code 3.
    cycle(1'b1, 1'b1, 3'd3, 1'b1);
    idle(5);
    cycle(1'b1, 1'b1, 3'd3, 1'b0);
    idle(3);

    // Reset in the middle of a hold, then accept on the first edge after release.
    offer(3'd6);
    idle(2);
    apply_reset();
    offer(3'd1);
    idle(5);

    for (int i = 0; i < 600; i++) begin
      logic [2:0] code;
      logic       par;
      code = 3'($urandom_range(0, 7));
      par  = ($urandom_range(0, 7) == 0) ? ~par_good(code) : par_good(code);
      if (i == 300) apply_reset();
      cycle(($urandom_range(0, 15) != 0), 1'($urandom_range(0, 1)), code, par);
    end
    idle(6);

    @(negedge clk);
    #1;
    check1("scoreboard drained", 8'(q4.size() + q1.size()), 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
